// File: rtl/fifo_rr_pop_arbiter_pkg.sv
// Shared definitions for the round-robin FIFO pop arbiter: FSM encodings and default widths.
package fifo_rr_pop_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_STALL = 2'd2
  } arb_state_t;

  localparam int NUM_FIFOS_D = 4;
  localparam int WORD_SIZE_D = 6;
  localparam int ID_L_D      = 2;
  localparam int BURST_D     = 4;
  localparam int BURST_L_D   = 3;

endpackage

// File: rtl/fifo_rr_pop_arbiter_rr_pick.sv
// Combinational round-robin scan: first requester after i_last, wrapping modulo NUM_FIFOS.
module fifo_rr_pop_arbiter_rr_pick
  import fifo_rr_pop_arbiter_pkg::*;
#(
  parameter int NUM_FIFOS = NUM_FIFOS_D,
  parameter int ID_L      = ID_L_D
) (
  input  logic [NUM_FIFOS-1:0] i_req,
  input  logic [ID_L-1:0]      i_last,
  output logic                 o_valid,
  output logic [ID_L-1:0]      o_idx
);

  function automatic logic [ID_L-1:0] wrap_idx(input logic [ID_L-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % NUM_FIFOS;
    return sum[ID_L-1:0];
  endfunction

  // Scan from the farthest candidate inward so the nearest requester after i_last wins;
  // offset NUM_FIFOS lands on i_last itself, letting a sole requester be re-picked.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = NUM_FIFOS; k >= 1; k--) begin
      if (i_req[wrap_idx(i_last, k)]) begin
        o_valid = 1'b1;
        o_idx   = wrap_idx(i_last, k);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_pop_arbiter.sv
// Round-robin read scheduler: pops source FIFOs in bursts of up to BURST words and
// forwards each popped word through one output register to the downstream FIFO.
module fifo_rr_pop_arbiter
  import fifo_rr_pop_arbiter_pkg::*;
#(
  parameter int NUM_FIFOS = NUM_FIFOS_D,
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int ID_L      = ID_L_D,
  parameter int BURST     = BURST_D,
  parameter int BURST_L   = BURST_L_D
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           arb_enable,
  input  logic [NUM_FIFOS-1:0]           fifo_empty,
  input  logic [NUM_FIFOS*WORD_SIZE-1:0] fifo_data,
  input  logic                           out_almost_full,
  output logic [NUM_FIFOS-1:0]           fifo_rd,
  output logic                           out_push,
  output logic [WORD_SIZE-1:0]           out_data,
  output logic [ID_L-1:0]                grant_id,
  output logic                           arb_idle
);

  arb_state_t           r_state;
  logic [ID_L-1:0]      r_grant;
  logic [ID_L-1:0]      r_last;
  logic [BURST_L-1:0]   r_burst_cnt;
  logic                 r_push;
  logic [WORD_SIZE-1:0] r_data;

  logic                 w_pop;
  logic                 w_burst_done;
  logic                 w_pick_vld;
  logic [ID_L-1:0]      w_pick_idx;
  logic [ID_L-1:0]      w_pick_base;
  logic [NUM_FIFOS-1:0] w_req;

  assign w_req = ~fifo_empty;

  // While granted, the next pick is scanned from the current grant, which becomes last_served.
  assign w_pick_base = (r_state == ST_GRANT) ? r_grant : r_last;

  fifo_rr_pop_arbiter_rr_pick #(
    .NUM_FIFOS(NUM_FIFOS),
    .ID_L     (ID_L)
  ) u_pick (
    .i_req  (w_req),
    .i_last (w_pick_base),
    .o_valid(w_pick_vld),
    .o_idx  (w_pick_idx)
  );

  assign w_pop = (r_state == ST_GRANT) && !fifo_empty[r_grant] &&
                 !out_almost_full && arb_enable;
  assign w_burst_done = (r_burst_cnt == BURST_L'(BURST - 1));

  always_comb begin
    fifo_rd = '0;
    if (w_pop) fifo_rd[r_grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_last      <= ID_L'(NUM_FIFOS - 1);
      r_burst_cnt <= '0;
      r_push      <= 1'b0;
      r_data      <= '0;
    end else begin
      r_push <= w_pop;
      if (w_pop) r_data <= fifo_data[r_grant*WORD_SIZE +: WORD_SIZE];

      case (r_state)
        ST_IDLE: begin
          if (arb_enable && w_pick_vld && !out_almost_full) begin
            r_state     <= ST_GRANT;
            r_grant     <= w_pick_idx;
            r_burst_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (!arb_enable) begin
            r_state <= ST_IDLE;
            r_last  <= r_grant;
          end else if (out_almost_full) begin
            r_state <= ST_STALL;
          end else if (w_pop && !w_burst_done) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end else begin
            // Burst finished or granted FIFO ran dry: hand over without an idle cycle.
            r_last      <= r_grant;
            r_burst_cnt <= '0;
            if (w_pick_vld) r_grant <= w_pick_idx;
            else            r_state <= ST_IDLE;
          end
        end
        ST_STALL: begin
          if (!arb_enable) begin
            r_state <= ST_IDLE;
            r_last  <= r_grant;
          end else if (!out_almost_full) begin
            r_state <= ST_GRANT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_push = r_push;
  assign out_data = r_data;
  assign grant_id = r_grant;
  assign arb_idle = (r_state == ST_IDLE);

endmodule

// File: tb/tb_fifo_rr_pop_arbiter.sv
// Directed bench for fifo_rr_pop_arbiter with a simple counting model of the source FIFOs.
module tb_fifo_rr_pop_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        arb_enable;
  logic [3:0]  fifo_empty;
  logic [23:0] fifo_data;
  logic        out_almost_full;
  logic [3:0]  fifo_rd;
  logic        out_push;
  logic [5:0]  out_data;
  logic [1:0]  grant_id;
  logic        arb_idle;

  int cnt [4];
  int rp  [4];
  logic nx_en, nx_af;
  logic [3:0] s_rd;
  logic       s_push;
  logic [5:0] s_data;
  logic [1:0] s_gid;
  logic       s_idle;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_rr_pop_arbiter #(
    .NUM_FIFOS(4), .WORD_SIZE(6), .ID_L(2), .BURST(4), .BURST_L(3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .arb_enable     (arb_enable),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .out_almost_full(out_almost_full),
    .fifo_rd        (fifo_rd),
    .out_push       (out_push),
    .out_data       (out_data),
    .grant_id       (grant_id),
    .arb_idle       (arb_idle)
  );

  // Word j of FIFO f carries {f, j} so every pushed word identifies its source and order.
  function automatic logic [5:0] word(input int f, input int j);
    logic [1:0] ff;
    logic [3:0] jj;
    ff = f[1:0];
    jj = j[3:0];
    return {ff, jj};
  endfunction

  task automatic drive_fifo();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]        = (cnt[i] == 0);
      fifo_data[i*6 +: 6]  = word(i, rp[i]);
    end
  endtask

  task automatic sample();
    s_rd   = fifo_rd;
    s_push = out_push;
    s_data = out_data;
    s_gid  = grant_id;
    s_idle = arb_idle;
  endtask

  task automatic step();
    for (int i = 0; i < 4; i++) begin
      if (s_rd[i]) begin
        cnt[i]--;
        rp[i]++;
      end
    end
    @(posedge clk);
    #1;
    arb_enable      = nx_en;
    out_almost_full = nx_af;
    drive_fifo();
    #1;
    sample();
  endtask

  task automatic load(input int f, input int n);
    cnt[f] = n;
    rp[f]  = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; arb_enable = 1'b0; out_almost_full = 1'b0; nx_en = 1'b0; nx_af = 1'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; rp[i] = 0; end
    drive_fifo();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 sample();
    checks++; if (s_idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", s_idle); end
    checks++; if (s_gid !== 2'd0) begin errors++; $display("FAIL rst_gid: got %0d want 0", s_gid); end
    checks++; if (s_push !== 1'b0) begin errors++; $display("FAIL rst_push: got %b want 0", s_push); end
    checks++; if (s_rd !== 4'b0000) begin errors++; $display("FAIL rst_rd: got %b want 0000", s_rd); end
    load(1, 3); nx_en = 1'b1;
    step();
    checks++; if (s_idle !== 1'b1) begin errors++; $display("FAIL rst_c0_idle: got %b want 1", s_idle); end
    step();
    checks++; if (s_rd !== 4'b0010) begin errors++; $display("FAIL rst_c1_rd: got %b want 0010", s_rd); end
    checks++; if (s_gid !== 2'd1) begin errors++; $display("FAIL rst_c1_gid: got %0d want 1", s_gid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (fifo_rd !== 4'b0000) begin errors++; $display("FAIL rst_async_rd: got %b want 0000", fifo_rd); end
    checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL rst_async_idle: got %b want 1", arb_idle); end
    s_rd = '0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_rel_gid: got %0d want 0", grant_id); end
    checks++; if (out_push !== 1'b0) begin errors++; $display("FAIL rst_rel_push: got %b want 0", out_push); end
    checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL rst_rel_idle: got %b want 1", arb_idle); end
    cnt[1] = 0; arb_enable = 1'b0; nx_en = 1'b0;
    drive_fifo();
    #1 sample();
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] e_rd;
    int p, f, j;
    for (int i = 0; i < 4; i++) load(i, 8);
    nx_en = 1'b1;
    step();
    checks++; if (s_idle !== 1'b1) begin errors++; $display("FAIL rr_c0_idle: got %b want 1", s_idle); end
    checks++; if (s_rd !== 4'b0000) begin errors++; $display("FAIL rr_c0_rd: got %b want 0000", s_rd); end
    for (int k = 1; k <= 33; k++) begin
      step();
      e_rd = (k <= 32) ? (4'b0001 << (((k - 1) / 4) % 4)) : 4'b0000;
      checks++; if (s_rd !== e_rd) begin errors++; $display("FAIL rr_rd c%0d: got %b want %b", k, s_rd, e_rd); end
      if (k <= 32) begin
        checks++;
        if (s_gid !== 2'(((k - 1) / 4) % 4)) begin
          errors++; $display("FAIL rr_gid c%0d: got %0d want %0d", k, s_gid, ((k - 1) / 4) % 4);
        end
      end
      if (k >= 2) begin
        p = k - 1;
        f = ((p - 1) / 4) % 4;
        j = ((p - 1) % 4) + 4 * ((p - 1) / 16);
        checks++; if (s_push !== 1'b1) begin errors++; $display("FAIL rr_push c%0d: got %b want 1", k, s_push); end
        checks++;
        if (s_data !== word(f, j)) begin
          errors++; $display("FAIL rr_data c%0d: got %h want %h", k, s_data, word(f, j));
        end
      end else begin
        checks++; if (s_push !== 1'b0) begin errors++; $display("FAIL rr_push c%0d: got %b want 0", k, s_push); end
      end
    end
    step();
    checks++; if (s_idle !== 1'b1) begin errors++; $display("FAIL rr_end_idle: got %b want 1", s_idle); end
    checks++; if (s_push !== 1'b0) begin errors++; $display("FAIL rr_end_push: got %b want 0", s_push); end
  endtask

  task automatic test_drain_to_idle();
    load(1, 2);
    step();
    checks++; if (s_idle !== 1'b1) begin errors++; $display("FAIL drain_c0_idle: got %b want 1", s_idle); end
    step();
    checks++; if (s_rd !== 4'b0010) begin errors++; $display("FAIL drain_c1_rd: got %b want 0010", s_rd); end
    checks++; if (s_gid !== 2'd1) begin errors++; $display("FAIL drain_c1_gid: got %0d want 1", s_gid); end
    step();
    checks++; if (s_rd !== 4'b0010) begin errors++; $display("FAIL drain_c2_rd: got %b want 0010", s_rd); end
    checks++; if (s_data !== word(1, 0) || s_push !== 1'b1) begin
      errors++; $display("FAIL drain_c2_out: got push=%b data=%h want push=1 data=%h", s_push, s_data, word(1, 0));
    end
    step();
    checks++; if (s_rd !== 4'b0000) begin errors++; $display("FAIL drain_c3_rd: got %b want 0000", s_rd); end
    checks++; if (s_data !== word(1, 1) || s_push !== 1'b1) begin
      errors++; $display("FAIL drain_c3_out: got push=%b data=%h want push=1 data=%h", s_push, s_data, word(1, 1));
    end
    step();
    checks++; if (s_idle !== 1'b1 || s_push !== 1'b0) begin
      errors++; $display("FAIL drain_c4: got idle=%b push=%b want idle=1 push=0", s_idle, s_push);
    end
  endtask

  task automatic test_stall();
    load(0, 4); load(1, 2);
    step();
    step();
    checks++; if (s_rd !== 4'b0001) begin errors++; $display("FAIL stall_c1_rd: got %b want 0001", s_rd); end
    step();
    checks++; if (s_rd !== 4'b0001) begin errors++; $display("FAIL stall_c2_rd: got %b want 0001", s_rd); end
    nx_af = 1'b1;
    step();
    checks++; if (s_rd !== 4'b0000) begin errors++; $display("FAIL stall_c3_rd: got %b want 0000", s_rd); end
    checks++; if (s_data !== word(0, 1) || s_push !== 1'b1) begin
      errors++; $display("FAIL stall_c3_out: got push=%b data=%h want push=1 data=%h", s_push, s_data, word(0, 1));
    end
    step();
    checks++; if (s_rd !== 4'b0000 || s_push !== 1'b0 || s_idle !== 1'b0 || s_gid !== 2'd0) begin
      errors++; $display("FAIL stall_c4: got rd=%b push=%b idle=%b gid=%0d want rd=0000 push=0 idle=0 gid=0",
                         s_rd, s_push, s_idle, s_gid);
    end
    nx_af = 1'b0;
    step();
    checks++; if (s_rd !== 4'b0000) begin errors++; $display("FAIL stall_c5_rd: got %b want 0000", s_rd); end
    step();
    checks++; if (s_rd !== 4'b0001 || s_gid !== 2'd0) begin
      errors++; $display("FAIL stall_c6: got rd=%b gid=%0d want rd=0001 gid=0", s_rd, s_gid);
    end
    step();
    checks++; if (s_rd !== 4'b0001 || s_data !== word(0, 2)) begin
      errors++; $display("FAIL stall_c7: got rd=%b data=%h want rd=0001 data=%h", s_rd, s_data, word(0, 2));
    end
    step();
    checks++; if (s_rd !== 4'b0010 || s_gid !== 2'd1 || s_data !== word(0, 3)) begin
      errors++; $display("FAIL stall_c8: got rd=%b gid=%0d data=%h want rd=0010 gid=1 data=%h",
                         s_rd, s_gid, s_data, word(0, 3));
    end
    step();
    checks++; if (s_rd !== 4'b0010 || s_data !== word(1, 0)) begin
      errors++; $display("FAIL stall_c9: got rd=%b data=%h want rd=0010 data=%h", s_rd, s_data, word(1, 0));
    end
    step();
    checks++; if (s_rd !== 4'b0000 || s_data !== word(1, 1) || s_push !== 1'b1) begin
      errors++; $display("FAIL stall_c10: got rd=%b push=%b data=%h want rd=0000 push=1 data=%h",
                         s_rd, s_push, s_data, word(1, 1));
    end
    step();
    checks++; if (s_idle !== 1'b1) begin errors++; $display("FAIL stall_c11_idle: got %b want 1", s_idle); end
  endtask

  task automatic test_self_regrant();
    load(2, 10);
    step();
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (s_rd !== 4'b0100 || s_gid !== 2'd2) begin
        errors++; $display("FAIL self_c%0d: got rd=%b gid=%0d want rd=0100 gid=2", k, s_rd, s_gid);
      end
      if (k >= 2) begin
        checks++; if (s_push !== 1'b1 || s_data !== word(2, k - 2)) begin
          errors++; $display("FAIL self_out c%0d: got push=%b data=%h want push=1 data=%h",
                             k, s_push, s_data, word(2, k - 2));
        end
      end
    end
    step();
    checks++; if (s_rd !== 4'b0000 || s_data !== word(2, 9) || s_idle !== 1'b0) begin
      errors++; $display("FAIL self_c11: got rd=%b data=%h idle=%b want rd=0000 data=%h idle=0",
                         s_rd, s_data, s_idle, word(2, 9));
    end
    step();
    checks++; if (s_idle !== 1'b1 || s_push !== 1'b0) begin
      errors++; $display("FAIL self_c12: got idle=%b push=%b want idle=1 push=0", s_idle, s_push);
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 4; i++) load(i, 4);
    step();
    step();
    checks++; if (s_rd !== 4'b1000 || s_gid !== 2'd3) begin
      errors++; $display("FAIL en_c1: got rd=%b gid=%0d want rd=1000 gid=3", s_rd, s_gid);
    end
    step();
    checks++; if (s_rd !== 4'b1000) begin errors++; $display("FAIL en_c2_rd: got %b want 1000", s_rd); end
    nx_en = 1'b0;
    step();
    checks++; if (s_rd !== 4'b0000) begin errors++; $display("FAIL en_c3_rd: got %b want 0000", s_rd); end
    checks++; if (s_push !== 1'b1 || s_data !== word(3, 1)) begin
      errors++; $display("FAIL en_c3_out: got push=%b data=%h want push=1 data=%h", s_push, s_data, word(3, 1));
    end
    step();
    checks++; if (s_idle !== 1'b1 || s_push !== 1'b0) begin
      errors++; $display("FAIL en_c4: got idle=%b push=%b want idle=1 push=0", s_idle, s_push);
    end
    nx_en = 1'b1;
    step();
    checks++; if (s_rd !== 4'b0000) begin errors++; $display("FAIL en_c5_rd: got %b want 0000", s_rd); end
    step();
    checks++; if (s_rd !== 4'b0001 || s_gid !== 2'd0) begin
      errors++; $display("FAIL en_c6: got rd=%b gid=%0d want rd=0001 gid=0", s_rd, s_gid);
    end
    step();
    checks++; if (s_push !== 1'b1 || s_data !== word(0, 0)) begin
      errors++; $display("FAIL en_c7: got push=%b data=%h want push=1 data=%h", s_push, s_data, word(0, 0));
    end
    nx_en = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    s_rd = '0; s_push = 1'b0; s_data = '0; s_gid = '0; s_idle = 1'b0;
    test_reset();
    test_round_robin();
    test_drain_to_idle();
    test_stall();
    test_self_regrant();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
